// File: rtl/imm_decode_stage.sv
// imm_decode_stage
// Registered decode stage sitting between fetch and execute. Each accepted
// instruction is classified by opcode into an immediate-select code. The
// 32-bit immediate is built before the entry is registered. A main register
// feeds the outputs. A skid register catches one extra entry, so IN_READY is
// a pure flop and never depends combinationally on OUT_READY.
//
// Handshake: a transfer happens on a rising CLK edge when VALID and READY are
// both high. A producer holds VALID and its payload stable until that edge.
// The downstream payload (OUT_*) is held stable while OUT_VALID=1 and
// OUT_READY=0.

module imm_decode_stage #(
   parameter int PC_W  = 32,
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic             FLUSH,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [31:0]      IN_INSTR,
   input  logic [PC_W-1:0]  IN_PC,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [31:0]      OUT_INSTR,
   output logic [PC_W-1:0]  OUT_PC,
   output logic [31:0]      OUT_IMM,
   output logic [2:0]       OUT_IMM_SEL,
   output logic             OUT_ILLEGAL,
   output logic [CNT_W-1:0] DEC_COUNT,
   output logic [1:0]       DBG_STATE
);

   // Immediate-select codes
   localparam logic [2:0] SEL_U     = 3'b000;
   localparam logic [2:0] SEL_J     = 3'b001;
   localparam logic [2:0] SEL_S     = 3'b010;
   localparam logic [2:0] SEL_B     = 3'b011;
   localparam logic [2:0] SEL_I     = 3'b100;
   localparam logic [2:0] SEL_SHIFT = 3'b101;
   localparam logic [2:0] SEL_NONE  = 3'b110;
   localparam logic [2:0] SEL_IU    = 3'b111;

   // Opcodes recognised by the decoder
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   // Occupancy: EMPTY = nothing held, ONE = main only, TWO = main + skid
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   state_t state_q, state_n;

   logic             in_ready_q;
   logic             out_valid_q;
   logic [CNT_W-1:0] count_q;

   // Main register (drives the outputs)
   logic [31:0]      main_instr_q;
   logic [PC_W-1:0]  main_pc_q;
   logic [31:0]      main_imm_q;
   logic [2:0]       main_sel_q;
   logic             main_ill_q;

   // Skid register (second entry, filled only while the head is stalled)
   logic [31:0]      skid_instr_q;
   logic [PC_W-1:0]  skid_pc_q;
   logic [31:0]      skid_imm_q;
   logic [2:0]       skid_sel_q;
   logic             skid_ill_q;

   // Decoded view of the incoming instruction
   logic [6:0]       opcode;
   logic [2:0]       funct3;
   logic [2:0]       dec_sel;
   logic             dec_ill;
   logic [31:0]      dec_imm;

   logic             accept;
   logic             fire;
   logic             ld_main_in;
   logic             ld_main_skid;
   logic             ld_skid;

   assign opcode = IN_INSTR[6:0];
   assign funct3 = IN_INSTR[14:12];

   assign accept = IN_VALID & in_ready_q;
   assign fire   = out_valid_q & OUT_READY;

   // Classify the incoming opcode into a select code and an illegal flag
   always_comb begin
      dec_sel = SEL_NONE;
      dec_ill = 1'b0;
      if (IN_INSTR[1:0] != 2'b11) begin
         dec_ill = 1'b1;
      end else begin
         case (opcode)
            OP_LUI, OP_AUIPC:            dec_sel = SEL_U;
            OP_JAL:                      dec_sel = SEL_J;
            OP_STORE:                    dec_sel = SEL_S;
            OP_BRANCH:                   dec_sel = SEL_B;
            OP_JALR, OP_LOAD:            dec_sel = SEL_I;
            OP_IMM: begin
               if (funct3 == 3'b001 || funct3 == 3'b101) begin
                  dec_sel = SEL_SHIFT;
               end else if (funct3 == 3'b011) begin
                  dec_sel = SEL_IU;
               end else begin
                  dec_sel = SEL_I;
               end
            end
            OP_OP, OP_FENCE, OP_SYSTEM:  dec_sel = SEL_NONE;
            default:                     dec_ill = 1'b1;
         endcase
      end
   end

   // Build the 32-bit immediate for the selected format
   always_comb begin
      dec_imm = 32'h0;
      case (dec_sel)
         SEL_U:     dec_imm = {IN_INSTR[31:12], 12'b0};
         SEL_J:     dec_imm = {{12{IN_INSTR[31]}}, IN_INSTR[19:12], IN_INSTR[20],
                               IN_INSTR[30:21], 1'b0};
         SEL_S:     dec_imm = {{20{IN_INSTR[31]}}, IN_INSTR[31:25], IN_INSTR[11:7]};
         SEL_B:     dec_imm = {{20{IN_INSTR[31]}}, IN_INSTR[7], IN_INSTR[30:25],
                               IN_INSTR[11:8], 1'b0};
         SEL_I:     dec_imm = {{20{IN_INSTR[31]}}, IN_INSTR[31:20]};
         SEL_SHIFT: dec_imm = {27'b0, IN_INSTR[24:20]};
         SEL_IU:    dec_imm = {20'b0, IN_INSTR[31:20]};
         default:   dec_imm = 32'h0;
      endcase
   end

   // Next-state and register-load decisions; FLUSH overrides everything
   always_comb begin
      state_n      = state_q;
      ld_main_in   = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
      if (FLUSH) begin
         state_n = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (accept) begin
                  ld_main_in = 1'b1;
                  state_n    = ST_ONE;
               end
            end
            ST_ONE: begin
               if (accept && fire) begin
                  ld_main_in = 1'b1;
               end else if (accept) begin
                  ld_skid = 1'b1;
                  state_n = ST_TWO;
               end else if (fire) begin
                  state_n = ST_EMPTY;
               end
            end
            ST_TWO: begin
               if (fire) begin
                  ld_main_skid = 1'b1;
                  state_n      = ST_ONE;
               end
            end
            default: state_n = ST_EMPTY;
         endcase
      end
   end

   // State register plus registered handshake flags derived from next state
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q     <= ST_EMPTY;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_n;
         in_ready_q  <= (state_n != ST_TWO);
         out_valid_q <= (state_n != ST_EMPTY);
      end
   end

   // Count output transfers; a flush does not clear or suppress the count
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         count_q <= '0;
      end else if (fire) begin
         count_q <= count_q + CNT_W'(1);
      end
   end

   // Main register: loads a fresh entry or promotes the skid entry
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         main_instr_q <= '0;
         main_pc_q    <= '0;
         main_imm_q   <= '0;
         main_sel_q   <= '0;
         main_ill_q   <= 1'b0;
      end else if (ld_main_in) begin
         main_instr_q <= IN_INSTR;
         main_pc_q    <= IN_PC;
         main_imm_q   <= dec_imm;
         main_sel_q   <= dec_sel;
         main_ill_q   <= dec_ill;
      end else if (ld_main_skid) begin
         main_instr_q <= skid_instr_q;
         main_pc_q    <= skid_pc_q;
         main_imm_q   <= skid_imm_q;
         main_sel_q   <= skid_sel_q;
         main_ill_q   <= skid_ill_q;
      end
   end

   // Skid register: captures an entry accepted while the head is stalled
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         skid_instr_q <= '0;
         skid_pc_q    <= '0;
         skid_imm_q   <= '0;
         skid_sel_q   <= '0;
         skid_ill_q   <= 1'b0;
      end else if (ld_skid) begin
         skid_instr_q <= IN_INSTR;
         skid_pc_q    <= IN_PC;
         skid_imm_q   <= dec_imm;
         skid_sel_q   <= dec_sel;
         skid_ill_q   <= dec_ill;
      end
   end

   assign IN_READY    = in_ready_q;
   assign OUT_VALID   = out_valid_q;
   assign OUT_INSTR   = main_instr_q;
   assign OUT_PC      = main_pc_q;
   assign OUT_IMM     = main_imm_q;
   assign OUT_IMM_SEL = main_sel_q;
   assign OUT_ILLEGAL = main_ill_q;
   assign DEC_COUNT   = count_q;
   assign DBG_STATE   = state_q;

endmodule

// File: tb/tb_imm_decode_stage.sv
// tb_imm_decode_stage
// Bench for imm_decode_stage. The reference model is a queue of expected
// entries plus a transfer counter. Immediates are derived arithmetically from
// the instruction fields. Inputs change at negedge, and outputs are compared
// at the following negedge.

module tb_imm_decode_stage;

   localparam int PC_W  = 32;
   localparam int CNT_W = 4;
   localparam int ENT_W = 32 + PC_W + 32 + 3 + 1;
   localparam int VEC_W = 2 + CNT_W + ENT_W;

   logic             clk;
   logic             rst_n;
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_instr;
   logic [PC_W-1:0]  in_pc;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_instr;
   logic [PC_W-1:0]  out_pc;
   logic [31:0]      out_imm;
   logic [2:0]       out_imm_sel;
   logic             out_illegal;
   logic [CNT_W-1:0] dec_count;
   logic [1:0]       dbg_state;

   int               n_checks;
   int               n_fails;
   logic [ENT_W-1:0] exp_q[$];
   logic [CNT_W-1:0] m_cnt;

   imm_decode_stage #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
      .CLK         (clk),
      .RESET_N     (rst_n),
      .FLUSH       (flush),
      .IN_VALID    (in_valid),
      .IN_READY    (in_ready),
      .IN_INSTR    (in_instr),
      .IN_PC       (in_pc),
      .OUT_VALID   (out_valid),
      .OUT_READY   (out_ready),
      .OUT_INSTR   (out_instr),
      .OUT_PC      (out_pc),
      .OUT_IMM     (out_imm),
      .OUT_IMM_SEL (out_imm_sel),
      .OUT_ILLEGAL (out_illegal),
      .DEC_COUNT   (dec_count),
      .DBG_STATE   (dbg_state)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference decode: {instr, pc, imm, sel, illegal}, with sign extension
   // done by subtracting the field's weight when its top bit is set
   function automatic logic [ENT_W-1:0] ref_entry(input logic [31:0] instr,
                                                  input logic [PC_W-1:0] pc);
      logic [31:0] imm;
      logic [2:0]  sel;
      logic        ill;
      logic [20:0] jraw;
      logic [12:0] braw;
      imm = 32'h0;
      sel = 3'd6;
      ill = 1'b0;
      jraw = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      braw = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      case (instr[6:0])
         7'h37, 7'h17: begin sel = 3'd0; imm = instr & 32'hFFFF_F000; end
         7'h6F: begin
            sel = 3'd1; imm = 32'(jraw);
            if (instr[31]) imm = imm - 32'h0020_0000;
         end
         7'h23: begin
            sel = 3'd2; imm = 32'({instr[31:25], instr[11:7]});
            if (instr[31]) imm = imm - 32'h1000;
         end
         7'h63: begin
            sel = 3'd3; imm = 32'(braw);
            if (instr[31]) imm = imm - 32'h2000;
         end
         7'h67, 7'h03: begin
            sel = 3'd4; imm = 32'(instr[31:20]);
            if (instr[31]) imm = imm - 32'h1000;
         end
         7'h13: begin
            if (instr[14:12] == 3'd1 || instr[14:12] == 3'd5) begin
               sel = 3'd5; imm = 32'(instr[24:20]);
            end else if (instr[14:12] == 3'd3) begin
               sel = 3'd7; imm = 32'(instr[31:20]);
            end else begin
               sel = 3'd4; imm = 32'(instr[31:20]);
               if (instr[31]) imm = imm - 32'h1000;
            end
         end
         7'h33, 7'h0F, 7'h73: begin sel = 3'd6; imm = 32'h0; end
         default: begin sel = 3'd6; imm = 32'h0; ill = 1'b1; end
      endcase
      return {instr, pc, imm, sel, ill};
   endfunction

   // Instruction generator weighted towards recognised opcodes
   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 12))
         0:  r[6:0] = 7'b0110111;
         1:  r[6:0] = 7'b0010111;
         2:  r[6:0] = 7'b1101111;
         3:  r[6:0] = 7'b0100011;
         4:  r[6:0] = 7'b1100011;
         5:  r[6:0] = 7'b1100111;
         6:  r[6:0] = 7'b0000011;
         7:  r[6:0] = 7'b0010011;
         8:  r[6:0] = 7'b0010011;
         9:  r[6:0] = 7'b0110011;
         10: r[6:0] = 7'b0001111;
         11: r[6:0] = 7'b1110011;
         default: ;
      endcase
      return r;
   endfunction

   // Observed vector; payload is masked when the model holds nothing
   function automatic logic [VEC_W-1:0] obs_vec();
      logic [ENT_W-1:0] d;
      d = '0;
      if (exp_q.size() != 0) d = {out_instr, out_pc, out_imm, out_imm_sel, out_illegal};
      return {out_valid, in_ready, dec_count, d};
   endfunction

   // Expected vector from the model
   function automatic logic [VEC_W-1:0] exp_vec();
      logic [ENT_W-1:0] d;
      d = '0;
      if (exp_q.size() != 0) d = exp_q[0];
      return {exp_q.size() != 0, exp_q.size() < 2, m_cnt, d};
   endfunction

   // Driver: apply one cycle of inputs and advance the model across the edge
   task automatic cycle(input logic v, input logic [31:0] instr,
                        input logic [PC_W-1:0] pc, input logic rdy, input logic fl);
      logic acc;
      logic fire;
      in_valid  = v;
      in_instr  = instr;
      in_pc     = pc;
      out_ready = rdy;
      flush     = fl;
      acc  = v && (exp_q.size() < 2);
      fire = (exp_q.size() != 0) && rdy;
      @(posedge clk);
      if (fire) begin
         void'(exp_q.pop_front());
         m_cnt = m_cnt + CNT_W'(1);
      end
      if (fl) exp_q.delete();
      else if (acc) exp_q.push_back(ref_entry(instr, pc));
      @(negedge clk);
      in_valid = 1'b0;
      flush    = 1'b0;
   endtask

   task automatic test_reset();
      n_checks++;
      if ({out_valid, in_ready, dec_count, out_instr, out_pc, out_imm, out_imm_sel, out_illegal}
          !== {1'b0, 1'b1, {CNT_W{1'b0}}, {ENT_W{1'b0}}}) begin
         n_fails++;
         $display("FAIL reset_values got v=%b r=%b cnt=%0d instr=%h imm=%h sel=%0d ill=%b, want v=0 r=1 cnt=0 data=0",
                  out_valid, in_ready, dec_count, out_instr, out_imm, out_imm_sel, out_illegal);
      end
      rst_n = 1'b1;
      cycle(1'b0, 32'h0, '0, 1'b1, 1'b0);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
         n_fails++;
         $display("FAIL reset_idle got %h want %h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_lui();
      cycle(1'b1, 32'h12345037, 32'h0000_1000, 1'b1, 1'b0);
      n_checks++;
      if ({out_valid, out_imm, out_imm_sel, out_illegal} !== {1'b1, 32'h12345000, 3'b000, 1'b0}) begin
         n_fails++;
         $display("FAIL lui_entry got v=%b imm=%h sel=%0d ill=%b want v=1 imm=12345000 sel=0 ill=0",
                  out_valid, out_imm, out_imm_sel, out_illegal);
      end
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
         n_fails++;
         $display("FAIL lui_model got %h want %h", obs_vec(), exp_vec());
      end
      cycle(1'b0, 32'h0, '0, 1'b1, 1'b0);
      n_checks++;
      if ({out_valid, dec_count} !== {1'b0, CNT_W'(1)}) begin
         n_fails++;
         $display("FAIL lui_count got v=%b cnt=%0d want v=0 cnt=1", out_valid, dec_count);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] ins[4]  = '{32'hFFF00093, 32'hFFF03093, 32'h4030D093, 32'hFE000EE3};
      logic [31:0] imms[4] = '{32'hFFFFFFFF, 32'h00000FFF, 32'h00000003, 32'hFFFFFFFC};
      logic [2:0]  sels[4] = '{3'b100, 3'b111, 3'b101, 3'b011};
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, ins[i], 32'h2000 + 32'(4 * i), 1'b1, 1'b0);
         n_checks++;
         if ({out_valid, in_ready, out_instr, out_imm, out_imm_sel} !== {1'b1, 1'b1, ins[i], imms[i], sels[i]}) begin
            n_fails++;
            $display("FAIL b2b_%0d got v=%b r=%b instr=%h imm=%h sel=%0d want v=1 r=1 instr=%h imm=%h sel=%0d",
                     i, out_valid, in_ready, out_instr, out_imm, out_imm_sel, ins[i], imms[i], sels[i]);
         end
         n_checks++;
         if (obs_vec() !== exp_vec()) begin
            n_fails++;
            $display("FAIL b2b_model_%0d got %h want %h", i, obs_vec(), exp_vec());
         end
      end
      cycle(1'b0, 32'h0, '0, 1'b1, 1'b0);
   endtask

   task automatic test_backpressure();
      logic [31:0] ins[3] = '{32'h00500113, 32'h00A00193, 32'h00F00213};
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, ins[i], 32'h3000 + 32'(4 * i), 1'b0, 1'b0);
         n_checks++;
         if (obs_vec() !== exp_vec()) begin
            n_fails++;
            $display("FAIL bp_fill_%0d got %h want %h", i, obs_vec(), exp_vec());
         end
      end
      n_checks++;
      if ({in_ready, out_valid, out_instr} !== {1'b0, 1'b1, ins[0]}) begin
         n_fails++;
         $display("FAIL bp_full got r=%b v=%b instr=%h want r=0 v=1 instr=%h", in_ready, out_valid, out_instr, ins[0]);
      end
      for (int i = 0; i < 2; i++) begin
         cycle(1'b0, 32'h0, '0, 1'b1, 1'b0);
         n_checks++;
         if (obs_vec() !== exp_vec()) begin
            n_fails++;
            $display("FAIL bp_drain_%0d got %h want %h", i, obs_vec(), exp_vec());
         end
      end
      n_checks++;
      if ({in_ready, out_valid} !== 2'b10) begin
         n_fails++;
         $display("FAIL bp_empty got r=%b v=%b want r=1 v=0", in_ready, out_valid);
      end
   endtask

   task automatic test_flush();
      cycle(1'b1, 32'h00100093, 32'h4000, 1'b0, 1'b0);
      cycle(1'b1, 32'h00200093, 32'h4004, 1'b0, 1'b0);
      cycle(1'b1, 32'hDEADB037, 32'h4008, 1'b0, 1'b1);
      n_checks++;
      if ({out_valid, in_ready, dec_count} !== {1'b0, 1'b1, m_cnt}) begin
         n_fails++;
         $display("FAIL flush_held got v=%b r=%b cnt=%0d want v=0 r=1 cnt=%0d", out_valid, in_ready, dec_count, m_cnt);
      end
      cycle(1'b1, 32'h00300093, 32'h400C, 1'b1, 1'b0);
      n_checks++;
      if ({out_valid, out_instr} !== {1'b1, 32'h00300093}) begin
         n_fails++;
         $display("FAIL flush_next got v=%b instr=%h want v=1 instr=00300093", out_valid, out_instr);
      end
      // Flush coinciding with a downstream transfer: the transfer is counted
      cycle(1'b0, 32'h0, '0, 1'b1, 1'b1);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
         n_fails++;
         $display("FAIL flush_fire got %h want %h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_illegal();
      logic [31:0] ins[3] = '{32'h00000000, 32'h0000007F, 32'h002081B3};
      logic        ills[3] = '{1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, ins[i], 32'h5000 + 32'(4 * i), 1'b1, 1'b0);
         n_checks++;
         if ({out_valid, out_illegal, out_imm_sel, out_imm} !== {1'b1, ills[i], 3'b110, 32'h0}) begin
            n_fails++;
            $display("FAIL illegal_%0d got v=%b ill=%b sel=%0d imm=%h want v=1 ill=%b sel=6 imm=0",
                     i, out_valid, out_illegal, out_imm_sel, out_imm, ills[i]);
         end
      end
      cycle(1'b0, 32'h0, '0, 1'b1, 1'b0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         cycle($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom_range(0, 2) != 0,
               $urandom_range(0, 24) == 0);
         n_checks++;
         if (obs_vec() !== exp_vec()) begin
            n_fails++;
            $display("FAIL random_%0d got %h want %h", i, obs_vec(), exp_vec());
         end
      end
      cycle(1'b0, 32'h0, '0, 1'b1, 1'b0);
      cycle(1'b0, 32'h0, '0, 1'b1, 1'b0);
   endtask

   task automatic test_async_reset();
      cycle(1'b1, 32'h00100093, 32'h6000, 1'b1, 1'b0);
      cycle(1'b1, 32'h00200093, 32'h6004, 1'b0, 1'b0);
      cycle(1'b1, 32'h00300093, 32'h6008, 1'b0, 1'b0);
      n_checks++;
      if ({out_valid, in_ready} !== 2'b10) begin
         n_fails++;
         $display("FAIL areset_pre got v=%b r=%b want v=1 r=0", out_valid, in_ready);
      end
      #2;
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      m_cnt = '0;
      n_checks++;
      if ({out_valid, in_ready, dec_count} !== {1'b0, 1'b1, {CNT_W{1'b0}}}) begin
         n_fails++;
         $display("FAIL areset_now got v=%b r=%b cnt=%0d want v=0 r=1 cnt=0", out_valid, in_ready, dec_count);
      end
      @(negedge clk);
      rst_n = 1'b1;
      cycle(1'b1, 32'hFE000EE3, 32'h7000, 1'b0, 1'b0);
      n_checks++;
      if ({out_valid, out_imm, out_imm_sel, out_pc} !== {1'b1, 32'hFFFFFFFC, 3'b011, 32'h7000}) begin
         n_fails++;
         $display("FAIL areset_first got v=%b imm=%h sel=%0d pc=%h want v=1 imm=fffffffc sel=3 pc=7000",
                  out_valid, out_imm, out_imm_sel, out_pc);
      end
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
         n_fails++;
         $display("FAIL areset_model got %h want %h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_wrap();
      logic [CNT_W-1:0] prev;
      for (int i = 0; i < 18; i++) begin
         prev = m_cnt;
         cycle(1'b1, rand_instr(), 32'h8000 + 32'(4 * i), 1'b1, 1'b0);
         n_checks++;
         if (obs_vec() !== exp_vec()) begin
            n_fails++;
            $display("FAIL wrap_%0d got %h want %h", i, obs_vec(), exp_vec());
         end
         if (prev == {CNT_W{1'b1}} && m_cnt == '0) begin
            n_checks++;
            if (dec_count !== {CNT_W{1'b0}}) begin
               n_fails++;
               $display("FAIL wrap_zero got cnt=%0d want 0", dec_count);
            end
         end
      end
      cycle(1'b0, 32'h0, '0, 1'b1, 1'b0);
   endtask

   // Sequencer
   initial begin
      n_checks  = 0;
      n_fails   = 0;
      m_cnt     = '0;
      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_instr  = 32'h0;
      in_pc     = '0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      test_reset();
      test_lui();
      test_back_to_back();
      test_backpressure();
      test_flush();
      test_illegal();
      test_random();
      test_async_reset();
      test_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/imm_decode_stage.md
Name: imm_decode_stage

Overview:
Registered decode stage between instruction fetch and execute. Accepts a fetched instruction and PC over a valid/ready handshake and classifies the opcode to an immediate-select code. It builds the 32-bit immediate internally, using the team's U/J/S/B/I/shift/unsigned-I encoding, and presents the result on a registered valid/ready output. Holds a 2-entry skid buffer so IN_READY never depends combinationally on OUT_READY; supports pipeline flush and counts decoded instructions.

Parameters:
PC_W, 32, width of PC field carried alongside instruction
CNT_W, 16, width of decoded-instruction counter

Ports:
CLK  input  1  clock, all state on rising edge
RESET_N  input  1  asynchronous active-low reset
FLUSH  input  1  synchronous flush; discards all held and incoming instructions
IN_VALID  input  1  upstream instruction valid
IN_READY  output  1  stage can accept; registered
IN_INSTR  input  32  fetched instruction
IN_PC  input  PC_W  PC of IN_INSTR
OUT_VALID  output  1  decoded entry valid
OUT_READY  input  1  downstream accepts
OUT_INSTR  output  32  instruction of head entry
OUT_PC  output  PC_W  PC of head entry
OUT_IMM  output  32  decoded immediate
OUT_IMM_SEL  output  3  select code used
OUT_ILLEGAL  output  1  unrecognised opcode or INSTR[1:0]!=2'b11
DEC_COUNT  output  CNT_W  number of output transfers since reset

Behaviour:
- Reset (async assert, sync release): state EMPTY, OUT_VALID=0, IN_READY=1, DEC_COUNT=0, all data outputs 0.
- Accept = IN_VALID&IN_READY; Fire = OUT_VALID&OUT_READY.
- Select decode on INSTR[6:0], combinational at input; captured with entry:
  - 0110111 LUI / 0010111 AUIPC -> 000 (U)
  - 1101111 JAL -> 001 (J)
  - 0100011 store -> 010 (S)
  - 1100011 branch -> 011 (B)
  - 1100111 JALR, 0000011 load -> 100 (I signed)
  - 0010011 OP-IMM: funct3 001/101 -> 101 (shift, imm={27'b0,INSTR[24:20]}); funct3 011 -> 111 (unsigned, imm={20'b0,INSTR[31:20]}); else 100
  - 0110011 OP, 0001111 FENCE, 1110011 SYSTEM -> 110, imm=0, legal
  - anything else, or INSTR[1:0]!=11 -> 110, imm=0, OUT_ILLEGAL=1
- Immediate formats: U={INSTR[31:12],12'b0}; J={12{INSTR[31]},INSTR[19:12],INSTR[20],INSTR[30:21],0}; S={20{INSTR[31]},INSTR[31:25],INSTR[11:7]}; B={20{INSTR[31]},INSTR[7],INSTR[30:25],INSTR[11:8],0}; I={20{INSTR[31]},INSTR[31:20]}.
- Entry = {INSTR, PC, IMM, SEL, ILLEGAL}, computed before registering; latency accept->OUT_VALID = 1 cycle.
- FSM (main register + skid register):
  - EMPTY: IN_READY=1, OUT_VALID=0. Accept -> load main, go ONE.
  - ONE: IN_READY=1, OUT_VALID=1. Accept&Fire -> main<=new, stay ONE. Accept&!Fire -> skid<=new, go TWO. Fire&!Accept -> EMPTY. Neither -> hold.
  - TWO: IN_READY=0, OUT_VALID=1. Fire -> main<=skid, go ONE. Else hold.
  - IN_READY registered: 1 in EMPTY and ONE, 0 in TWO.
- Ordering strictly FIFO; outputs stable while OUT_VALID&!OUT_READY.
- FLUSH has highest priority: next state EMPTY, IN_READY=1, OUT_VALID=0. A same-cycle Accept is dropped. A same-cycle Fire completes downstream and is counted.
- DEC_COUNT += 1 per Fire; wraps modulo 2^CNT_W; not cleared by FLUSH.
- RESET_N low mid-transfer: all entries discarded immediately, outputs return to reset values in the same cycle.

Test Plan:
- LUI 0x12345037, OUT_READY=1 -> next cycle OUT_VALID=1, OUT_IMM=0x12345000, SEL=000, ILLEGAL=0, DEC_COUNT=1.
- Back-to-back ADDI 0xFFF00093, SLTIU 0xFFF03093, SRAI 0x4030D093, BEQ 0xFE000EE3 -> in order: IMM 0xFFFFFFFF/100, 0x00000FFF/111, 0x00000003/101, 0xFFFFFFFC/011; one per cycle.
- OUT_READY=0, three IN_VALID instructions -> two accepted, IN_READY=0 from cycle after second accept. Raise OUT_READY -> both emerge in order, IN_READY back to 1.
- Two entries held, FLUSH=1 with IN_VALID=1 -> next cycle OUT_VALID=0, IN_READY=1, DEC_COUNT unchanged, flushed input never appears.
- INSTR 0x00000000 and 0x0000007F -> OUT_ILLEGAL=1, SEL=110, IMM=0. ADD 0x002081B3 -> ILLEGAL=0, SEL=110.
- Pull RESET_N low in TWO state, asynchronously -> OUT_VALID=0 and DEC_COUNT=0 immediately; after release, first accept produces correct entry. DEC_COUNT with CNT_W=4 wraps 15->0.
